// File: rtl/hazard_pkg.sv
// Shared definitions for the Tnew hazard pipeline: default widths, the stage
// entry layout, the saturating Tnew decrement and the forward-select code
// meaning "read the register file".
package hazard_pkg;

    // Default widths of Tnew/Tuse and of a register address.
    localparam int TW_DEF = 2;
    localparam int AW_DEF = 5;

    // Forward-select value that means "no forwarding, use the register file".
    localparam int FWD_RF = 0;

    // One tracked stage: does it write a register, which one, and how many
    // cycles until its result exists.
    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] addr;
        logic [TW_DEF-1:0] tnew;
    } stage_entry_t;

    // Saturating decrement, applied on every stage transfer. Written on a
    // 32-bit operand so that any Tnew width can use it after a size cast.
    function automatic logic [31:0] sat_dec(input logic [31:0] x);
        return (x == 32'd0) ? 32'd0 : x - 32'd1;
    endfunction

endpackage

// File: rtl/tnew_hazard_pipe_stage.sv
// tnew_stage: a single {valid, addr, Tnew} pipeline register.
// Asynchronous reset, synchronous flush, hold while en is low, bubble insert,
// and a saturating Tnew decrement on every load. Register $0 is never
// loaded as valid, so bubbles always carry addr=0 and tnew=0.
module tnew_stage
    import hazard_pkg::*;
#(
    parameter int TW = TW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic          bubble,
    input  logic          d_valid,
    input  logic [AW-1:0] d_addr,
    input  logic [TW-1:0] d_tnew,
    output logic          q_valid,
    output logic [AW-1:0] q_addr,
    output logic [TW-1:0] q_tnew
);

    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [TW-1:0] r_tnew;

    // A load is real only for a valid, non-$0 writer that is not being bubbled.
    logic w_load;
    assign w_load = !bubble && d_valid && (d_addr != '0);

    // Stage register: reset > flush > hold (!en) > load or bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_tnew  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_tnew  <= '0;
        end else if (en) begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_addr  <= d_addr;
                r_tnew  <= TW'(sat_dec(32'(d_tnew)));
            end else begin
                r_valid <= 1'b0;
                r_addr  <= '0;
                r_tnew  <= '0;
            end
        end
    end

    assign q_valid = r_valid;
    assign q_addr  = r_addr;
    assign q_tnew  = r_tnew;

endmodule

// File: rtl/tnew_hazard_pipe.sv
// tnew_hazard_pipe: tracks {valid, dest, Tnew} of the instructions in the
// NSTAGE stages after D (stage 0 youngest) and derives, for the two D source
// operands, the RAW stall request and forwarding selects.
// Optional build macro: HAZARD_STATS_EN adds a saturating stall_cnt output
// counting cycles with stall_req=1 and en=1.
module tnew_hazard_pipe
    import hazard_pkg::*;
#(
    parameter  int NSTAGE = 3,
    parameter  int TW     = TW_DEF,
    parameter  int AW     = AW_DEF,
    localparam int FSW    = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [AW-1:0]        in_addr,
    input  logic [TW-1:0]        in_tnew,
    input  logic [AW-1:0]        rs_addr,
    input  logic [AW-1:0]        rt_addr,
    input  logic [TW-1:0]        rs_tuse,
    input  logic [TW-1:0]        rt_tuse,
    output logic [NSTAGE-1:0]    st_valid,
    output logic [NSTAGE*AW-1:0] st_addr,
    output logic [NSTAGE*TW-1:0] st_tnew,
    output logic                 stall_req,
    output logic [FSW-1:0]       fwd_sel_rs,
    output logic [FSW-1:0]       fwd_sel_rt
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    // Unpacked view of the stage contents, shared by the chain and the
    // match logic.
    logic [NSTAGE-1:0] w_v;
    logic [AW-1:0]     w_a [NSTAGE];
    logic [TW-1:0]     w_t [NSTAGE];

    // ------------------------------------------------------------------
    // Stage chain. Stage 0 loads from D (and takes the D-stall bubble);
    // every later stage loads from its predecessor. An invalid predecessor
    // already holds {0,0,0}, so passing it on reproduces the bubble.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                tnew_stage #(.TW(TW), .AW(AW)) u_stage (
                    .clk     (clk),
                    .reset   (reset),
                    .en      (en),
                    .flush   (flush),
                    .bubble  (stall),
                    .d_valid (in_valid),
                    .d_addr  (in_addr),
                    .d_tnew  (in_tnew),
                    .q_valid (w_v[gi]),
                    .q_addr  (w_a[gi]),
                    .q_tnew  (w_t[gi])
                );
            end else begin : g_body
                tnew_stage #(.TW(TW), .AW(AW)) u_stage (
                    .clk     (clk),
                    .reset   (reset),
                    .en      (en),
                    .flush   (flush),
                    .bubble  (1'b0),
                    .d_valid (w_v[gi-1]),
                    .d_addr  (w_a[gi-1]),
                    .d_tnew  (w_t[gi-1]),
                    .q_valid (w_v[gi]),
                    .q_addr  (w_a[gi]),
                    .q_tnew  (w_t[gi])
                );
            end

            assign st_addr[gi*AW +: AW] = w_a[gi];
            assign st_tnew[gi*TW +: TW] = w_t[gi];
        end
    endgenerate

    assign st_valid = w_v;

    // ------------------------------------------------------------------
    // Source matching. Index 0 is rs, index 1 is rt. The youngest valid
    // writer of the source register decides: ready (tnew=0) forwards from
    // its stage, not ready either stalls (result later than Tuse) or waits
    // for a later stage to forward. Older writers are shadowed.
    // ------------------------------------------------------------------
    logic [AW-1:0]  w_src_addr  [2];
    logic [TW-1:0]  w_src_tuse  [2];
    logic [FSW-1:0] w_src_sel   [2];
    logic           w_src_stall [2];

    assign w_src_addr[0] = rs_addr;
    assign w_src_addr[1] = rt_addr;
    assign w_src_tuse[0] = rs_tuse;
    assign w_src_tuse[1] = rt_tuse;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic           w_hit;
            logic [FSW-1:0] w_hit_sel;
            logic [TW-1:0]  w_hit_tnew;

            // Scan oldest to youngest so the youngest match is the last
            // assignment and overrides every older one.
            always_comb begin
                w_hit      = 1'b0;
                w_hit_sel  = FSW'(FWD_RF);
                w_hit_tnew = '0;
                for (int i = NSTAGE - 1; i >= 0; i--) begin
                    if (w_v[i] && (w_a[i] == w_src_addr[gi]) && (w_src_addr[gi] != '0)) begin
                        w_hit      = 1'b1;
                        w_hit_sel  = FSW'(i + 1);
                        w_hit_tnew = w_t[i];
                    end
                end
            end

            // Turn the youngest match into a forward select and stall vote.
            always_comb begin
                w_src_sel[gi]   = FSW'(FWD_RF);
                w_src_stall[gi] = 1'b0;
                if (w_hit) begin
                    if (w_hit_tnew == '0) begin
                        w_src_sel[gi] = w_hit_sel;
                    end else begin
                        w_src_stall[gi] = (w_hit_tnew > w_src_tuse[gi]);
                    end
                end
            end
        end
    endgenerate

    assign fwd_sel_rs = w_src_sel[0];
    assign fwd_sel_rt = w_src_sel[1];
    assign stall_req  = w_src_stall[0] | w_src_stall[1];

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;

    // Count advancing cycles spent stalled; saturate, survive flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall_req && en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Statistics counter not built: no extra port, no extra state.
`endif

endmodule

// File: tb/tb_tnew_hazard_pipe.sv
// Directed bench for tnew_hazard_pipe with default parameters
// (NSTAGE=3, TW=2, AW=5). Build with HAZARD_STATS_EN to cover stall_cnt.
module tb_tnew_hazard_pipe;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, stall, flush;
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [1:0]  in_tnew;
    logic [4:0]  rs_addr, rt_addr;
    logic [1:0]  rs_tuse, rt_tuse;
    logic [2:0]  st_valid;
    logic [14:0] st_addr;
    logic [5:0]  st_tnew;
    logic        stall_req;
    logic [1:0]  fwd_sel_rs, fwd_sel_rt;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int n_total  = 0;
    int n_passed = 0;

    tnew_hazard_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_addr    (in_addr),
        .in_tnew    (in_tnew),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_tuse    (rs_tuse),
        .rt_tuse    (rt_tuse),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_tnew    (st_tnew),
        .stall_req  (stall_req),
        .fwd_sel_rs (fwd_sel_rs),
        .fwd_sel_rt (fwd_sel_rt)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [1:0] t);
        in_valid = v;
        in_addr  = a;
        in_tnew  = t;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 5'd0, 2'd0);
        rs_addr = 5'd0; rt_addr = 5'd0; rs_tuse = 2'd0; rt_tuse = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(st_valid), 32'h0);
        chk("rst_addr",  32'(st_addr),  32'h0);
        chk("rst_tnew",  32'(st_tnew),  32'h0);
        reset = 1'b0;

        // Decrement chain: addr 8, tnew 2 walks through the stages.
        drive(1'b1, 5'd8, 2'd2); tick();
        chk("chain0_valid", 32'(st_valid), 32'h1);
        chk("chain0_addr",  32'(st_addr),  32'h0008);
        chk("chain0_tnew",  32'(st_tnew),  32'h01);
        drive(1'b0, 5'd0, 2'd0); tick();
        chk("chain1_valid", 32'(st_valid), 32'h2);
        chk("chain1_addr",  32'(st_addr),  32'h0100);
        chk("chain1_tnew",  32'(st_tnew),  32'h00);
        tick();
        chk("chain2_valid", 32'(st_valid), 32'h4);
        chk("chain2_addr",  32'(st_addr),  32'h2000);
        tick();
        chk("chain_drain",  32'(st_valid), 32'h0);

        // Stall: stage0 = {1,8,2}.
        drive(1'b1, 5'd8, 2'd3); tick();
        drive(1'b0, 5'd0, 2'd0);
        chk("stall_st0tnew", 32'(st_tnew), 32'h02);
        rs_addr = 5'd8; rs_tuse = 2'd0; #1;
        chk("stall_tuse0", 32'(stall_req), 32'h1);
        chk("stall_fwd",   32'(fwd_sel_rs), 32'(FWD_RF));
        rs_tuse = 2'd2; #1;
        chk("stall_tuse2", 32'(stall_req), 32'h0);
        rs_tuse = 2'd1; #1;
        chk("stall_tuse1", 32'(stall_req), 32'h1);
        rs_addr = 5'd0; rs_tuse = 2'd0; #1;
        chk("stall_rs0", 32'(stall_req), 32'h0);

        // Forward priority: stage0={1,9,0}, stage1={1,9,0}, stage2={1,8,0}.
        drive(1'b1, 5'd9, 2'd1); tick();
        drive(1'b1, 5'd9, 2'd0); tick();
        drive(1'b0, 5'd0, 2'd0);
        rt_addr = 5'd9; rs_addr = 5'd8; #1;
        chk("fwd_rt_young", 32'(fwd_sel_rt), 32'h1);
        chk("fwd_rs_st2",   32'(fwd_sel_rs), 32'h3);
        chk("fwd_nostall",  32'(stall_req),  32'h0);
        rs_addr = 5'd0;
        tick();
        chk("fwd_rt_st1", 32'(fwd_sel_rt), 32'h2);
        // Young not-ready writer shadows a ready older one in stage2.
        drive(1'b1, 5'd9, 2'd3); tick();
        drive(1'b0, 5'd0, 2'd0);
        rt_tuse = 2'd3; #1;
        chk("shadow_fwd",    32'(fwd_sel_rt), 32'(FWD_RF));
        chk("shadow_nostl",  32'(stall_req),  32'h0);
        rt_tuse = 2'd1; #1;
        chk("shadow_stall",  32'(stall_req),  32'h1);
        rt_addr = 5'd0; rt_tuse = 2'd0; #1;
        chk("src0_stall", 32'(stall_req), 32'h0);

        // $0 destination never becomes valid. State: {1,9,2},{0},{1,9,0}.
        drive(1'b1, 5'd0, 2'd2); tick();
        chk("r0_valid", 32'(st_valid), 32'h2);
        chk("r0_tnew",  32'(st_tnew),  32'h04);
        // D stall bubbles stage0 while stage1 takes old stage0.
        drive(1'b1, 5'd5, 2'd2); tick();
        drive(1'b1, 5'd6, 2'd2); stall = 1'b1; tick();
        stall = 1'b0;
        chk("bub_valid", 32'(st_valid), 32'h2);
        chk("bub_addr",  32'(st_addr),  32'h00A0);
        chk("bub_tnew",  32'(st_tnew),  32'h00);

        // Freeze: stage0={1,7,2}, stage1 empty, stage2={1,5,0}.
        drive(1'b1, 5'd7, 2'd3); tick();
        chk("frz_pre", 32'(st_addr), 32'h1407);
        en = 1'b0; drive(1'b1, 5'd3, 2'd3);
        repeat (3) tick();
        chk("frz_valid", 32'(st_valid), 32'h5);
        chk("frz_addr",  32'(st_addr),  32'h1407);
        chk("frz_tnew",  32'(st_tnew),  32'h02);
        rs_addr = 5'd7; #1;
        chk("frz_stall", 32'(stall_req), 32'h1);
        rs_addr = 5'd5; #1;
        chk("frz_fwd",   32'(fwd_sel_rs), 32'h3);
        rs_addr = 5'd0;
        flush = 1'b1; tick();
        flush = 1'b0; en = 1'b1;
        chk("flush_valid", 32'(st_valid), 32'h0);
        chk("flush_addr",  32'(st_addr),  32'h0);

        // Mid-cycle reset with populated stages.
        drive(1'b1, 5'd4, 2'd1); tick();
        drive(1'b1, 5'd6, 2'd3); tick();
        drive(1'b0, 5'd0, 2'd0);
        rt_addr = 5'd4; rs_addr = 5'd6; rs_tuse = 2'd0; #1;
        chk("pre_rst_fwd",   32'(fwd_sel_rt), 32'h2);
        chk("pre_rst_stall", 32'(stall_req),  32'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(st_valid),   32'h0);
        chk("mid_rst_addr",  32'(st_addr),    32'h0);
        chk("mid_rst_tnew",  32'(st_tnew),    32'h0);
        chk("mid_rst_stall", 32'(stall_req),  32'h0);
        chk("mid_rst_fwdrs", 32'(fwd_sel_rs), 32'h0);
        chk("mid_rst_fwdrt", 32'(fwd_sel_rt), 32'h0);
        #2 reset = 1'b0;
        rt_addr = 5'd0;

`ifdef HAZARD_STATS_EN
        tick();
        chk("cnt_reset", stall_cnt, 32'd0);
        // Keep reloading {1,10,2} so rs=10/tuse=0 stalls every cycle.
        rs_addr = 5'd10; rs_tuse = 2'd0;
        drive(1'b1, 5'd10, 2'd3); tick();
        chk("cnt_first", stall_cnt, 32'd0);
        repeat (4) tick();
        chk("cnt_four", stall_cnt, 32'd4);
        en = 1'b0; repeat (2) tick();
        chk("cnt_frozen", stall_cnt, 32'd4);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("cnt_flush", stall_cnt, 32'd4);
        en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/tnew_hazard_pipe.md
Name: tnew_hazard_pipe

Overview:
- Parametrised successor to the single Tnew stage register: tracks {valid, dest addr, Tnew} across NSTAGE pipeline stages (default E/M/W).
- Every stage transfer applies a saturating decrement to Tnew.
- Also compares up to two source operands (rs, rt with Tuse) against the tracked stages and produces the stall request and forwarding selects for the hazard unit in D.

Parameters:
- NSTAGE, 3, number of tracked stages; minimum 1. Stage 0 is the youngest.
- TW, 2, Tnew/Tuse width.
- AW, 5, register address width.
- Localparam FSW = $clog2(NSTAGE+1), forward-select width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  global advance enable; 0 freezes all stages (mul/div busy).
- stall  in  1  D-stage stall; inserts a bubble into stage 0 while later stages advance.
- flush  in  1  synchronous clear of all stages.
- in_valid  in  1  D instruction writes a register.
- in_addr  in  AW  D destination register.
- in_tnew  in  TW  D Tnew, measured relative to D.
- rs_addr, rt_addr  in  AW each  D source registers.
- rs_tuse, rt_tuse  in  TW each  D Tuse per source.
- st_valid  out  NSTAGE  per-stage valid.
- st_addr  out  NSTAGE*AW  flattened, stage i at [i*AW +: AW].
- st_tnew  out  NSTAGE*TW  flattened, same packing.
- stall_req  out  1  combinational RAW stall request.
- fwd_sel_rs, fwd_sel_rt  out  FSW each  0 = register file; k = forward from stage k-1.

Behaviour:
- Reset: asynchronous. All st_valid/st_addr/st_tnew go to 0 immediately; stall_req = 0 and fwd_sel = 0 follow combinationally.
- Update priority each posedge: reset > flush > !en (hold all) > advance.
- sat_dec(x) = (x==0) ? 0 : x-1. Applied on every transfer, including D -> stage 0.
- Advance, stage 0:
  - If stall is asserted, in_valid=0, or in_addr=0: bubble {0, 0, 0}.
  - Otherwise: {1, in_addr, sat_dec(in_tnew)}.
- Advance, stage i ≥ 1: {v[i-1], a[i-1], sat_dec(t[i-1])}.
- Bubbles always carry addr=0 and tnew=0.
- flush: all stages cleared in that cycle, regardless of en or stall.
- Register $0: never valid in any stage and never hazards. A source addr of 0 gives fwd_sel=0 and contributes no stall.
- Source match, per source s: m = youngest stage i with v[i]=1 and a[i]=s_addr.
  - No match: fwd_sel_s = 0; no stall contribution.
  - t[m] == 0: fwd_sel_s = m+1.
  - t[m] > 0: fwd_sel_s = 0. Stall contribution if t[m] > s_tuse; otherwise wait with no forward yet, as forwarding occurs from a later stage.
  - Older matches are ignored; the youngest writer shadows them.
- stall_req = OR over both sources. It is purely combinational from the current stage state and D inputs, with 0-cycle latency.
- Latency: an instruction reaches stage i at i+1 cycles after acceptance with en=1.
- No freeze anomalies: with en=0 the Tnew values do not decrement, and stall_req/fwd_sel remain evaluated combinationally.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds output stall_cnt [31:0], counting cycles with stall_req=1 and en=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset; not cleared by flush.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - Default TW/AW constants.
  - Typedef stage_entry_t {valid, addr, tnew}.
  - Function sat_dec.
  - Constant FWD_RF = 0.
- Sub-module tnew_stage: one stage register with async reset, flush, en hold, bubble insert and sat_dec on load. Instantiated NSTAGE times via generate.
- The match/priority logic stays in the top module.

Test Plan:
- Reset: assert reset mid-cycle with stages populated -> all st_* = 0 immediately; stall_req=0; fwd_sel_rs=fwd_sel_rt=0.
- Decrement chain: en=1, load in_valid=1, addr=8, tnew=2, then bubbles -> st_tnew stage0=1, then stage1=0, stage2=0. st_valid drains after 3 cycles.
- Stall: stage0={1,8,t=2}, rs_addr=8, rs_tuse=0 -> stall_req=1, fwd_sel_rs=0. With rs_tuse=2 -> stall_req=0.
- Forward priority: stage0={1,9,0} and stage1={1,9,0}, rt_addr=9 -> fwd_sel_rt=1. Invalidate stage0 -> fwd_sel_rt=2.
- $0 and stall bubble: in_addr=0, in_valid=1 -> stage0 valid=0. stall=1 with valid input -> stage0 bubble while stage1 receives the old stage0.
- Freeze/flush: en=0 for 3 cycles -> st_* unchanged. flush=1 with en=0 -> all cleared next edge. With HAZARD_STATS_EN: 4 stall cycles with en=1 -> stall_cnt=4.
